// File: rtl/sprite_engine.sv
// sprite_engine: multi-frame, multi-bit-colour sprite renderer with integer
// zoom, H/V mirroring and vsync-paced frame animation. Fixed 2-clock latency
// from x/y to color/drawing. Bitmap RAM is loaded through a write port.
// Optional collision detector is built when SPRITE_ENGINE_COLLISION_EN is
// defined (adds other_drawing input and sticky collision output).
module sprite_engine #(
   parameter int SPRITE_W   = 32,
   parameter int SPRITE_H   = 32,
   parameter int COLOR_BITS = 4,
   parameter int NUM_FRAMES = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int FRAME_HOLD = 8,
   localparam int FW = $clog2(NUM_FRAMES),
   localparam int XW = $clog2(SPRITE_W),
   localparam int YW = $clog2(SPRITE_H),
   localparam int AW = FW + YW + XW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [9:0]            x,
   input  logic [9:0]            y,
   input  logic                  vsync,
   input  logic [9:0]            sprite_x,
   input  logic [9:0]            sprite_y,
   input  logic                  enable,
   input  logic                  flip_h,
   input  logic                  flip_v,
   input  logic                  anim_en,
   input  logic [FW-1:0]         frame_sel,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [COLOR_BITS-1:0] wr_data,
`ifdef SPRITE_ENGINE_COLLISION_EN
   input  logic                  other_drawing,
   output logic                  collision,
`endif
   output logic [COLOR_BITS-1:0] color,
   output logic                  drawing,
   output logic [FW-1:0]         frame_idx
);

   localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_LOG2);
   localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_LOG2);
   localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);

   // vsync synchroniser plus one history flop for falling-edge detection
   logic vs_s0_q, vs_s1_q, vs_s2_q;
   logic vs_edge;

   // shadow registers, refreshed only at vertical blank
   logic [9:0] sx_q, sx_d, sy_q, sy_d;
   logic       en_q, en_d, fh_q, fh_d, fv_q, fv_d;

   // animation state
   logic [HW-1:0] hold_q, hold_d;
   logic [FW-1:0] frame_q, frame_d;

   // pipeline
   logic                  act1_q, act1_d, act2_q, act2_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [COLOR_BITS-1:0] pix_q, pix_d;

   logic [COLOR_BITS-1:0] mem [2**AW];

   logic [10:0]   x11, y11, sx11, sy11, dx, dy;
   logic          in_x, in_y;
   logic [XW-1:0] bx;
   logic [YW-1:0] by;

   assign vs_edge = vs_s2_q & ~vs_s1_q;

   // shadow capture and frame animation, both paced by the vsync falling edge
   always_comb begin
      sx_d    = sx_q;
      sy_d    = sy_q;
      en_d    = en_q;
      fh_d    = fh_q;
      fv_d    = fv_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      if (vs_edge) begin
         sx_d = sprite_x;
         sy_d = sprite_y;
         en_d = enable;
         fh_d = flip_h;
         fv_d = flip_v;
      end
      if (!anim_en) begin
         hold_d = '0;
         if (vs_edge) frame_d = frame_sel;
      end else if (vs_edge) begin
         if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            frame_d = frame_q + 1'b1;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   // window test (11-bit so a sprite hanging past 1023 clips rather than wraps)
   // and bitmap address generation
   always_comb begin
      x11  = {1'b0, x};
      y11  = {1'b0, y};
      sx11 = {1'b0, sx_q};
      sy11 = {1'b0, sy_q};
      dx   = x11 - sx11;
      dy   = y11 - sy11;
      in_x = (x11 >= sx11) && (x11 < sx11 + SPAN_X);
      in_y = (y11 >= sy11) && (y11 < sy11 + SPAN_Y);
      bx   = XW'(dx >> SCALE_LOG2);
      by   = YW'(dy >> SCALE_LOG2);
      if (fh_q) bx = ~bx;
      if (fv_q) by = ~by;
      act1_d = in_x && in_y && en_q;
      addr_d = {frame_q, by, bx};
      act2_d = act1_q;
      pix_d  = mem[addr_q];
   end

   // state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_s0_q <= 1'b0;
         vs_s1_q <= 1'b0;
         vs_s2_q <= 1'b0;
         sx_q    <= '0;
         sy_q    <= '0;
         en_q    <= 1'b0;
         fh_q    <= 1'b0;
         fv_q    <= 1'b0;
         hold_q  <= '0;
         frame_q <= '0;
         act1_q  <= 1'b0;
         addr_q  <= '0;
         act2_q  <= 1'b0;
         pix_q   <= '0;
      end else begin
         vs_s0_q <= vsync;
         vs_s1_q <= vs_s0_q;
         vs_s2_q <= vs_s1_q;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         en_q    <= en_d;
         fh_q    <= fh_d;
         fv_q    <= fv_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
         act1_q  <= act1_d;
         addr_q  <= addr_d;
         act2_q  <= act2_d;
         pix_q   <= pix_d;
      end
   end

   // bitmap RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign drawing   = act2_q && (pix_q != '0);
   assign color     = drawing ? pix_q : '0;
   assign frame_idx = frame_q;

`ifdef SPRITE_ENGINE_COLLISION_EN
   logic coll_q, coll_d;

   // sticky hit flag; a hit in the clearing cycle takes priority
   always_comb begin
      coll_d = coll_q;
      if (vs_edge) coll_d = 1'b0;
      if (drawing && other_drawing) coll_d = 1'b1;
   end

   // collision flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   assign collision = coll_q;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: two instances (zoom 1x and 2x) share stimulus and
// are compared against a pixel-level reference model of the sprite rules.
module tb_sprite_engine;
   localparam int W = 32, H = 32, NF = 4, FH = 2;

   logic       clk = 1'b0;
   logic       reset, vsync, enable, flip_h, flip_v, anim_en, wr_en;
   logic [9:0] x, y, sprite_x, sprite_y;
   logic [1:0] frame_sel;
   logic [11:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] c0, c1;
   logic       d0, d1;
   logic [1:0] f0, f1;
`ifdef SPRITE_ENGINE_COLLISION_EN
   logic       od0, col0, col1;
`endif

   int checks = 0, errors = 0;

   // reference model state
   int mem_m [NF*W*H];
   int m_sx, m_sy, m_frame, m_hold;
   bit m_en, m_fh, m_fv;

   always #5 clk = ~clk;

   sprite_engine #(.FRAME_HOLD(FH)) u0 (
      .clk(clk), .reset(reset), .x(x), .y(y), .vsync(vsync),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .enable(enable),
      .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en), .frame_sel(frame_sel),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SPRITE_ENGINE_COLLISION_EN
      .other_drawing(od0), .collision(col0),
`endif
      .color(c0), .drawing(d0), .frame_idx(f0));

   sprite_engine #(.SCALE_LOG2(1), .FRAME_HOLD(FH)) u1 (
      .clk(clk), .reset(reset), .x(x), .y(y), .vsync(vsync),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .enable(enable),
      .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en), .frame_sel(frame_sel),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SPRITE_ENGINE_COLLISION_EN
      .other_drawing(1'b0), .collision(col1),
`endif
      .color(c1), .drawing(d1), .frame_idx(f1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic int fa(input int f, input int r, input int c);
      return f*W*H + r*W + c;
   endfunction

   // expected colour at screen (xx,yy) for zoom 2^s
   function automatic int exp_pix(input int s, input int xx, input int yy);
      int bx, by;
      if (!m_en) return 0;
      if (xx < m_sx || xx >= m_sx + (W << s)) return 0;
      if (yy < m_sy || yy >= m_sy + (H << s)) return 0;
      bx = (xx - m_sx) >> s;
      by = (yy - m_sy) >> s;
      if (m_fh) bx = W - 1 - bx;
      if (m_fv) by = H - 1 - by;
      return mem_m[fa(m_frame, by, bx)];
   endfunction

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; wr_addr = 12'(a); wr_data = 4'(d);
      @(posedge clk); #1;
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   // one vsync pulse; model applies the shadow/animation rules at its fall
   task automatic vfall();
      vsync = 1'b1;
      repeat (4) @(posedge clk);
      vsync = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      m_sx = int'(sprite_x); m_sy = int'(sprite_y);
      m_en = enable; m_fh = flip_h; m_fv = flip_v;
      if (!anim_en) begin
         m_hold = 0; m_frame = int'(frame_sel);
      end else if (m_hold == FH - 1) begin
         m_hold = 0; m_frame = (m_frame + 1) % NF;
      end else begin
         m_hold++;
      end
      chk("frame_idx0", 32'(f0), 32'(m_frame));
      chk("frame_idx1", 32'(f1), 32'(m_frame));
   endtask

   // stream one new x per clock and check each result exactly 2 clocks later
   task automatic scan(input int yy, input int x0, input int n);
      int q0[$], q1[$];
      int e0, e1, xx;
      for (int i = 0; i < n + 2; i++) begin
         @(posedge clk); #1;
         if (i >= 2) begin
            e0 = q0.pop_front(); e1 = q1.pop_front();
            chk("color0", 32'(c0), 32'(e0));
            chk("drawing0", 32'(d0), 32'(e0 != 0));
            chk("color1", 32'(c1), 32'(e1));
            chk("drawing1", 32'(d1), 32'(e1 != 0));
         end
         if (i < n) begin
            xx = (x0 + i) % 1024;
            x = 10'(xx); y = 10'(yy);
            q0.push_back(exp_pix(0, xx, yy));
            q1.push_back(exp_pix(1, xx, yy));
         end else begin
            x = 10'd0; y = 10'd0;
         end
      end
   endtask

   initial begin
      int seq [8];
      seq = '{0, 1, 1, 2, 2, 3, 3, 0};
      reset = 1'b0; vsync = 1'b0; enable = 1'b0; flip_h = 1'b0; flip_v = 1'b0;
      anim_en = 1'b0; wr_en = 1'b0; x = '0; y = '0; sprite_x = '0; sprite_y = '0;
      frame_sel = '0; wr_addr = '0; wr_data = '0;
`ifdef SPRITE_ENGINE_COLLISION_EN
      od0 = 1'b0;
`endif
      m_sx = 0; m_sy = 0; m_en = 0; m_fh = 0; m_fv = 0; m_frame = 0; m_hold = 0;

      // reset state
      #12;
      chk("rst_color", 32'(c0), 0);
      chk("rst_drawing", 32'(d0), 0);
      chk("rst_frame", 32'(f0), 0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // random bitmap, ~25% transparent
      for (int a = 0; a < NF*W*H; a++)
         wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));

      // basic placement at (100,50), frame 0
      wr(fa(0, 0, 0), 5);
      sprite_x = 10'd100; sprite_y = 10'd50; enable = 1'b1;
      vfall();
      scan(50, 96, 16);
      scan(51, 96, 8);
      scan(50, 126, 42);

`ifdef SPRITE_ENGINE_COLLISION_EN
      x = 10'd100; y = 10'd50;
      repeat (3) @(posedge clk); #1;
      chk("coll_pre", 32'(col0), 0);
      od0 = 1'b1;
      @(posedge clk); #1;
      od0 = 1'b0;
      chk("coll_set", 32'(col0), 1);
      x = 10'd0;
      repeat (4) @(posedge clk); #1;
      chk("coll_sticky", 32'(col0), 1);
      chk("coll_other", 32'(col1), 0);
      vfall();
      chk("coll_clear", 32'(col0), 0);
`endif

      // horizontal mirror, then a mid-frame position change that must wait
      wr(fa(0, 0, 31), 7);
      flip_h = 1'b1;
      vfall();
      scan(50, 96, 16);
      sprite_x = 10'd300;
      scan(50, 96, 16);
      flip_v = 1'b1;
      vfall();
      scan(50 + 31, 296, 72);
      flip_h = 1'b0; flip_v = 1'b0;

      // animation: 8 vsync falls with FRAME_HOLD=2
      frame_sel = '0;
      vfall();
      anim_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vfall();
         chk("anim_seq", 32'(f0), 32'(seq[i]));
      end
      anim_en = 1'b0;

      // right-edge clipping and transparent pixel
      frame_sel = 2'd0;
      sprite_x = 10'd1010; sprite_y = 10'd50;
      wr(fa(0, 0, 10), 9);
      wr(fa(0, 0, 5), 9);
      wr(fa(0, 0, 11), 0);
      vfall();
      scan(50, 1000, 40);

      // static frame select
      frame_sel = 2'd2; sprite_x = 10'd200;
      vfall();
      scan(60, 196, 72);

      // randomized placements, flips and animation
      for (int r = 0; r < 10; r++) begin
         sprite_x  = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 1023));
         sprite_y  = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 1023));
         enable    = ($urandom_range(0, 3) != 0);
         flip_h    = 1'($urandom_range(0, 1));
         flip_v    = 1'($urandom_range(0, 1));
         anim_en   = 1'($urandom_range(0, 1));
         frame_sel = 2'($urandom_range(0, 3));
         vfall();
         scan((m_sy + int'($urandom_range(0, 66))) % 1024, (m_sx + 1020) % 1024, 72);
      end

      // reset pulsed mid-line on an opaque pixel
      anim_en = 1'b0; frame_sel = 2'd0; enable = 1'b1; flip_h = 1'b0; flip_v = 1'b0;
      sprite_x = 10'd100; sprite_y = 10'd50;
      vfall();
      x = 10'd100; y = 10'd50;
      repeat (3) @(posedge clk); #1;
      chk("pre_rst_drawing", 32'(d0), 1);
      reset = 1'b0;
      #1;
      chk("midrst_color", 32'(c0), 0);
      chk("midrst_drawing", 32'(d0), 0);
      chk("midrst_frame", 32'(f0), 0);
`ifdef SPRITE_ENGINE_COLLISION_EN
      chk("midrst_coll", 32'(col0), 0);
`endif
      @(negedge clk); reset = 1'b1;
      m_sx = 0; m_sy = 0; m_en = 0; m_fh = 0; m_fv = 0; m_frame = 0; m_hold = 0;
      scan(50, 96, 16);
      scan(0, 0, 8);
      vfall();
      scan(50, 96, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
